// File: rtl/serial_mag_comp_if.sv
// Operand/result handshake bundle for the bit-serial magnitude comparator.
// The master side supplies operands and consumes results; the slave is the comparator.
interface serial_mag_comp_if #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic             yg;
    logic             yl;
    logic             ye;
    logic             busy;
    logic [CW-1:0]    bit_cnt;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, yg, yl, ye, busy, bit_cnt
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, yg, yl, ye, busy, bit_cnt
    );
endinterface

// File: rtl/serial_mag_comp.sv
// Bit-serial unsigned magnitude comparator: one MSB-first bit pair per clock,
// registered one-hot greater/lesser/equal result behind a valid/ready handshake.
module serial_mag_comp #(
    parameter int WIDTH      = 8,
    parameter int EARLY_EXIT = 1,
    parameter int CW         = $clog2(WIDTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    serial_mag_comp_if.slave    bus
);
    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        DONE
    } state_t;

    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             yg_q, yg_d;
    logic             yl_q, yl_d;
    logic             ye_q, ye_d;

    logic msb_a, msb_b, pair_differs, recorded;

    assign msb_a        = sa_q[WIDTH-1];
    assign msb_b        = sb_q[WIDTH-1];
    assign pair_differs = msb_a ^ msb_b;
    // yg/yl double as the "first difference seen" record during a full scan.
    assign recorded     = yg_q | yl_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            cnt_q   <= '0;
            yg_q    <= 1'b0;
            yl_q    <= 1'b0;
            ye_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            cnt_q   <= cnt_d;
            yg_q    <= yg_d;
            yl_q    <= yl_d;
            ye_q    <= ye_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        cnt_d   = cnt_q;
        yg_d    = yg_q;
        yl_d    = yl_q;
        ye_d    = ye_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    sa_d    = bus.a;
                    sb_d    = bus.b;
                    cnt_d   = '0;
                    yg_d    = 1'b0;
                    yl_d    = 1'b0;
                    ye_d    = 1'b0;
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                cnt_d = cnt_q + 1'b1;
                sa_d  = {sa_q[WIDTH-2:0], 1'b0};
                sb_d  = {sb_q[WIDTH-2:0], 1'b0};
                if (pair_differs && !recorded) begin
                    yg_d = msb_a & ~msb_b;
                    yl_d = ~msb_a & msb_b;
                end
                if (pair_differs && (EARLY_EXIT != 0)) begin
                    state_d = DONE;
                end else if (cnt_q == LAST_CNT) begin
                    ye_d    = ~(recorded | pair_differs);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.busy      = (state_q == COMPARE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.yg        = yg_q;
    assign bus.yl        = yl_q;
    assign bus.ye        = ye_q;
    assign bus.bit_cnt   = cnt_q;
endmodule

// File: tb/tb_serial_mag_comp.sv
// Drives an early-exit and a full-scan comparator with shared operands and
// checks each result against an arithmetic reference model.
module tb_serial_mag_comp;
    localparam int W = 8;

    typedef struct packed {
        logic [4:0] lat;
        logic       yg;
        logic       yl;
        logic       ye;
        logic [3:0] cnt;
        logic       idle_after;
    } res_t;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         out_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           vectors;
    int           miscompares;

    serial_mag_comp_if #(.WIDTH(W)) ife ();
    serial_mag_comp_if #(.WIDTH(W)) ifn ();

    assign ife.in_valid  = in_valid;
    assign ife.a         = a;
    assign ife.b         = b;
    assign ife.out_ready = out_ready;
    assign ifn.in_valid  = in_valid;
    assign ifn.a         = a;
    assign ifn.b         = b;
    assign ifn.out_ready = out_ready;

    serial_mag_comp #(.WIDTH(W), .EARLY_EXIT(1)) dut_e (.clk(clk), .rst(rst), .bus(ife.slave));
    serial_mag_comp #(.WIDTH(W), .EARLY_EXIT(0)) dut_n (.clk(clk), .rst(rst), .bus(ifn.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: plain unsigned comparison; early-exit latency is the 1-based
    // MSB-first position of the highest differing bit.
    function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input bit early);
        res_t r;
        int   d;
        int   lat;
        d   = int'(x ^ y);
        lat = (early && d != 0) ? (W + 1 - $clog2(d + 1)) : W;
        r.lat        = 5'(lat);
        r.yg         = (x > y);
        r.yl         = (x < y);
        r.ye         = (x == y);
        r.cnt        = 4'(lat);
        r.idle_after = 1'b1;
        return r;
    endfunction

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, output res_t oe, output res_t on);
        int guard;
        guard = 0;
        oe = '0;
        on = '0;
        oe.lat = 5'h1F;
        on.lat = 5'h1F;
        while (!(ife.in_ready && ifn.in_ready) && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        a = x;
        b = y;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int c = 1; c <= W + 1; c++) begin
            @(negedge clk);
            if (ife.out_valid && oe.lat == 5'h1F) begin
                oe.lat = 5'(c); oe.yg = ife.yg; oe.yl = ife.yl; oe.ye = ife.ye; oe.cnt = ife.bit_cnt;
            end else if (oe.lat != 5'h1F && c == int'(oe.lat) + 1) begin
                oe.idle_after = ife.in_ready && !ife.out_valid;
            end
            if (ifn.out_valid && on.lat == 5'h1F) begin
                on.lat = 5'(c); on.yg = ifn.yg; on.yl = ifn.yl; on.ye = ifn.ye; on.cnt = ifn.bit_cnt;
            end else if (on.lat != 5'h1F && c == int'(on.lat) + 1) begin
                on.idle_after = ifn.in_ready && !ifn.out_valid;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if ({ife.in_ready, ife.out_valid, ife.yg, ife.yl, ife.ye, ife.busy, ife.bit_cnt} !== {1'b1, 5'b0, 4'd0}) begin
            miscompares++;
            $display("FAIL reset_early got %b want %b", {ife.in_ready, ife.out_valid, ife.yg, ife.yl, ife.ye, ife.busy, ife.bit_cnt}, {1'b1, 9'b0});
        end
        vectors++;
        if ({ifn.in_ready, ifn.out_valid, ifn.yg, ifn.yl, ifn.ye, ifn.busy, ifn.bit_cnt} !== {1'b1, 5'b0, 4'd0}) begin
            miscompares++;
            $display("FAIL reset_full got %b want %b", {ifn.in_ready, ifn.out_valid, ifn.yg, ifn.yl, ifn.ye, ifn.busy, ifn.bit_cnt}, {1'b1, 9'b0});
        end
        rst = 1'b0;
    endtask

    task automatic test_equal;
        res_t oe, on;
        run_op(8'hA5, 8'hA5, oe, on);
        vectors++;
        if (oe !== model(8'hA5, 8'hA5, 1'b1)) begin
            miscompares++;
            $display("FAIL equal_early got %h want %h", oe, model(8'hA5, 8'hA5, 1'b1));
        end
        vectors++;
        if (on !== model(8'hA5, 8'hA5, 1'b0)) begin
            miscompares++;
            $display("FAIL equal_full got %h want %h", on, model(8'hA5, 8'hA5, 1'b0));
        end
    endtask

    task automatic test_early_exit;
        res_t oe, on;
        logic [W-1:0] xs [2];
        logic [W-1:0] ys [2];
        xs[0] = 8'h80; ys[0] = 8'h7F;
        xs[1] = 8'h01; ys[1] = 8'h02;
        for (int i = 0; i < 2; i++) begin
            run_op(xs[i], ys[i], oe, on);
            vectors++;
            if (oe !== model(xs[i], ys[i], 1'b1)) begin
                miscompares++;
                $display("FAIL early_exit_%0d got %h want %h", i, oe, model(xs[i], ys[i], 1'b1));
            end
        end
    endtask

    task automatic test_full_scan;
        res_t oe, on;
        run_op(8'h80, 8'h7F, oe, on);
        vectors++;
        if (on !== model(8'h80, 8'h7F, 1'b0)) begin
            miscompares++;
            $display("FAIL full_scan got %h want %h", on, model(8'h80, 8'h7F, 1'b0));
        end
    endtask

    task automatic test_backpressure;
        res_t oe, on;
        out_ready = 1'b0;
        a = 8'h3C;
        b = 8'h3D;
        in_valid = 1'b1;
        @(negedge clk);
        for (int c = 1; c <= W + 5; c++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            in_valid = c[0];
            @(negedge clk);
            if (c >= W) begin
                vectors++;
                if ({ife.out_valid, ife.yg, ife.yl, ife.ye, ife.bit_cnt} !== {4'b1010, 4'd8}) begin
                    miscompares++;
                    $display("FAIL hold_early_%0d got %b want %b", c, {ife.out_valid, ife.yg, ife.yl, ife.ye, ife.bit_cnt}, {4'b1010, 4'd8});
                end
                vectors++;
                if ({ifn.out_valid, ifn.yg, ifn.yl, ifn.ye, ifn.bit_cnt} !== {4'b1010, 4'd8}) begin
                    miscompares++;
                    $display("FAIL hold_full_%0d got %b want %b", c, {ifn.out_valid, ifn.yg, ifn.yl, ifn.ye, ifn.bit_cnt}, {4'b1010, 4'd8});
                end
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if ({ife.out_valid, ife.in_ready, ifn.out_valid, ifn.in_ready} !== 4'b0101) begin
            miscompares++;
            $display("FAIL release got %b want %b", {ife.out_valid, ife.in_ready, ifn.out_valid, ifn.in_ready}, 4'b0101);
        end
        run_op(8'hC3, 8'h3C, oe, on);
        vectors++;
        if ({oe, on} !== {model(8'hC3, 8'h3C, 1'b1), model(8'hC3, 8'h3C, 1'b0)}) begin
            miscompares++;
            $display("FAIL after_release got %h want %h", {oe, on}, {model(8'hC3, 8'h3C, 1'b1), model(8'hC3, 8'h3C, 1'b0)});
        end
    endtask

    task automatic test_reset_mid;
        res_t oe, on;
        a = 8'h00;
        b = 8'hFF;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        vectors++;
        if ({ife.in_ready, ife.out_valid, ife.busy, ife.bit_cnt, ifn.in_ready, ifn.out_valid, ifn.busy, ifn.bit_cnt} !== {3'b100, 4'd0, 3'b100, 4'd0}) begin
            miscompares++;
            $display("FAIL reset_mid got %b want %b", {ife.in_ready, ife.out_valid, ife.busy, ife.bit_cnt, ifn.in_ready, ifn.out_valid, ifn.busy, ifn.bit_cnt}, {3'b100, 4'd0, 3'b100, 4'd0});
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++;
            if ({ife.out_valid, ifn.out_valid} !== 2'b00) begin
                miscompares++;
                $display("FAIL no_stale_valid_%0d got %b want %b", c, {ife.out_valid, ifn.out_valid}, 2'b00);
            end
        end
        run_op(8'h10, 8'h0F, oe, on);
        vectors++;
        if ({oe, on} !== {model(8'h10, 8'h0F, 1'b1), model(8'h10, 8'h0F, 1'b0)}) begin
            miscompares++;
            $display("FAIL post_reset got %h want %h", {oe, on}, {model(8'h10, 8'h0F, 1'b1), model(8'h10, 8'h0F, 1'b0)});
        end
    endtask

    task automatic test_random;
        res_t oe, on;
        logic [W-1:0] x, y;
        for (int i = 0; i < 40; i++) begin
            x = 8'($urandom);
            case (i % 4)
                0:       y = x;
                1:       y = x ^ (8'd1 << $urandom_range(W - 1, 0));
                default: y = 8'($urandom);
            endcase
            run_op(x, y, oe, on);
            vectors++;
            if (oe !== model(x, y, 1'b1)) begin
                miscompares++;
                $display("FAIL random_early a=%h b=%h got %h want %h", x, y, oe, model(x, y, 1'b1));
            end
            vectors++;
            if (on !== model(x, y, 1'b0)) begin
                miscompares++;
                $display("FAIL random_full a=%h b=%h got %h want %h", x, y, on, model(x, y, 1'b0));
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        a           = '0;
        b           = '0;
        test_reset();
        test_equal();
        test_early_exit();
        test_full_scan();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
